// File: rtl/hbm_latency_delay.sv
// Fixed-latency, order-preserving delay line modelling HBM access time.
// Optional occupancy/stall statistics are enabled with `HBM_LATENCY_DELAY_STATS_EN.
module hbm_latency_delay #(
    parameter int unsigned Latency   = 100,
    parameter int unsigned Depth     = 32,
    parameter int unsigned DataWidth = 64
) (
    input  logic                       clk_i,
    input  logic                       rst_ni,
    input  logic                       in_valid_i,
    output logic                       in_ready_o,
    input  logic [DataWidth-1:0]       in_data_i,
    output logic                       out_valid_o,
    input  logic                       out_ready_i,
    output logic [DataWidth-1:0]       out_data_o,
`ifdef HBM_LATENCY_DELAY_STATS_EN
    output logic [31:0]                stall_cnt_o,
    output logic [$clog2(Depth):0]     max_count_o,
`endif
    output logic [$clog2(Depth):0]     count_o
);

    localparam int unsigned IdxW = $clog2(Depth);
    localparam int unsigned PtrW = IdxW + 1;
    localparam int unsigned TW   = $clog2(Latency + 1) + 1;

    logic [PtrW-1:0]      wr_ptr_q, rd_ptr_q;
    logic [TW-1:0]        now_q;
    logic [DataWidth-1:0] data_q  [Depth];
    logic [TW-1:0]        stamp_q [Depth];
    logic [Depth-1:0]     ripe_q;

    logic [PtrW-1:0]      count;
    logic [IdxW-1:0]      rd_idx, wr_idx;
    logic [TW-1:0]        head_age;
    logic [IdxW-1:0]      rel   [Depth];
    logic [TW-1:0]        age   [Depth];
    logic [Depth-1:0]     ripe_set;
    logic                 push, pop;

    // Handshake and head status, derived only from registered state
    always_comb begin
        count       = wr_ptr_q - rd_ptr_q;
        rd_idx      = rd_ptr_q[IdxW-1:0];
        wr_idx      = wr_ptr_q[IdxW-1:0];
        head_age    = now_q - stamp_q[rd_idx];
        in_ready_o  = count < PtrW'(Depth);
        out_valid_o = (count != '0) && (ripe_q[rd_idx] || head_age == TW'(Latency));
        out_data_o  = data_q[rd_idx];
        count_o     = count;
        push        = in_valid_i && in_ready_o;
        pop         = out_valid_o && out_ready_i;
    end

    // Sticky ripe marking keeps long-stalled beats valid across timestamp wrap
    always_comb begin
        ripe_set = '0;
        for (int i = 0; i < Depth; i++) begin
            rel[i]      = IdxW'(i) - rd_idx;
            age[i]      = now_q - stamp_q[i];
            ripe_set[i] = (PtrW'(rel[i]) < count) && (age[i] == TW'(Latency));
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            now_q    <= '0;
            ripe_q   <= '0;
            for (int i = 0; i < Depth; i++) begin
                data_q[i]  <= '0;
                stamp_q[i] <= '0;
            end
        end else begin
            now_q  <= now_q + TW'(1);
            ripe_q <= ripe_q | ripe_set;
            if (push) begin
                data_q[wr_idx]  <= in_data_i;
                stamp_q[wr_idx] <= now_q;
                ripe_q[wr_idx]  <= 1'b0;
                wr_ptr_q        <= wr_ptr_q + PtrW'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + PtrW'(1);
            end
        end
    end

`ifdef HBM_LATENCY_DELAY_STATS_EN
    logic [PtrW-1:0] count_next;

    always_comb begin
        count_next = (wr_ptr_q + PtrW'(push)) - (rd_ptr_q + PtrW'(pop));
    end

    // Saturating stall counter and occupancy high-watermark
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            stall_cnt_o <= '0;
            max_count_o <= '0;
        end else begin
            if (out_valid_o && !out_ready_i && stall_cnt_o != '1) begin
                stall_cnt_o <= stall_cnt_o + 32'd1;
            end
            if (count_next > max_count_o) begin
                max_count_o <= count_next;
            end
        end
    end
`endif

endmodule

// File: tb/tb_hbm_latency_delay.sv
// Scoreboard bench for hbm_latency_delay: a queue of (payload, due cycle) is the reference.
module tb_hbm_latency_delay;

    localparam int unsigned L  = 4;
    localparam int unsigned D  = 8;
    localparam int unsigned W  = 16;
    localparam int unsigned CW = $clog2(D) + 1;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          in_valid;
    logic          in_ready;
    logic [W-1:0]  in_data;
    logic          out_valid;
    logic          out_ready;
    logic [W-1:0]  out_data;
    logic [CW-1:0] count;
`ifdef HBM_LATENCY_DELAY_STATS_EN
    logic [31:0]   stall_cnt;
    logic [CW-1:0] max_count;
`endif

    hbm_latency_delay #(.Latency(L), .Depth(D), .DataWidth(W)) dut (
        .clk_i       (clk),
        .rst_ni      (rst_n),
        .in_valid_i  (in_valid),
        .in_ready_o  (in_ready),
        .in_data_i   (in_data),
        .out_valid_o (out_valid),
        .out_ready_i (out_ready),
        .out_data_o  (out_data),
`ifdef HBM_LATENCY_DELAY_STATS_EN
        .stall_cnt_o (stall_cnt),
        .max_count_o (max_count),
`endif
        .count_o     (count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0] d;
        int           due;
    } ent_t;

    ent_t q[$];
    int   cyc       = 0;
    int   tests     = 0;
    int   fails     = 0;
    bit   exp_valid = 1'b0;
    int   exp_stall = 0;
    int   exp_max   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, act, exp);
        end
    endtask

    // Monitor: compare DUT outputs against the model mid-cycle
    always @(negedge clk) begin
        if (!rst_n) begin
            q.delete();
            exp_stall = 0;
            exp_max   = 0;
        end
        exp_valid = (q.size() > 0) && (cyc >= q[0].due);
        check("out_valid", 64'(out_valid), 64'(exp_valid));
        check("in_ready", 64'(in_ready), 64'(q.size() < D));
        check("count", 64'(count), 64'(q.size()));
        if (exp_valid && out_valid) check("out_data", 64'(out_data), 64'(q[0].d));
    end

    // Model update at the edge: pop, then push (no same-cycle pass-through when full)
    always @(posedge clk) begin
        if (rst_n) begin
            bit acc;
            acc = in_valid && (q.size() < D);
            if (exp_valid && !out_ready) exp_stall++;
            if (exp_valid && out_ready) void'(q.pop_front());
            if (acc) q.push_back('{d: in_data, due: cyc + L});
            if (q.size() > exp_max) exp_max = q.size();
        end
        cyc++;
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b0;
        step(2);
        check("reset_data", 64'(out_data), 64'h0);
        rst_n = 1'b1;
        step(2);

        // Single beat
        out_ready = 1'b1;
        in_valid  = 1'b1;
        in_data   = 16'h00A5;
        step(1);
        in_valid = 1'b0;
        step(L + 4);

        // Burst fill past capacity, then drain
        out_ready = 1'b0;
        for (int i = 0; i <= D; i++) begin
            in_valid = 1'b1;
            in_data  = W'(i);
            step(1);
        end
        in_valid = 1'b0;
        step(4);
        out_ready = 1'b1;
        step(D + 4);

        // Long stall across timestamp wrap
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_data   = 16'hBEEF;
        step(1);
        in_valid = 1'b0;
        step(40);
        out_ready = 1'b1;
        step(3);

        // Continuous streaming
        for (int i = 0; i < 200; i++) begin
            in_valid = 1'b1;
            in_data  = W'($urandom);
            step(1);
        end
        in_valid = 1'b0;
        step(L + 2);

        // Random traffic with back-pressure
        for (int i = 0; i < 300; i++) begin
            in_valid  = ($urandom_range(0, 2) != 0);
            in_data   = W'($urandom);
            out_ready = ($urandom_range(0, 3) != 0);
            step(1);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        step(D + L + 2);

`ifdef HBM_LATENCY_DELAY_STATS_EN
        @(negedge clk);
        check("stall_cnt", 64'(stall_cnt), 64'(exp_stall));
        check("max_count", 64'(max_count), 64'(exp_max));
        step(1);
`endif

        // Reset with beats in flight
        out_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            in_valid = 1'b1;
            in_data  = W'(16'h100 + i);
            step(1);
        end
        in_valid = 1'b0;
        rst_n    = 1'b0;
        step(1);
        rst_n     = 1'b1;
        out_ready = 1'b1;
        step(20);
`ifdef HBM_LATENCY_DELAY_STATS_EN
        @(negedge clk);
        check("stall_cnt_rst", 64'(stall_cnt), 64'h0);
        check("max_count_rst", 64'(max_count), 64'h0);
`endif
        check("drained", 64'(q.size()), 64'h0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
